// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 front-panel I/O conditioning.
package slc3_io_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } btn_state_t;

   localparam int unsigned DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/btn_debounce.sv
// One active-low key: 2-flop synchronizer, four-state debounce FSM with a
// stability counter, debounced level and one-cycle press strobe.
module btn_debounce
   import slc3_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic level,
   output logic pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   btn_state_t       state_reg;
   btn_state_t       state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             pulse_reg;
   logic             pulse_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         state_reg <= RELEASED;
         cnt_reg   <= '0;
         pulse_reg <= 1'b0;
      end else begin
         sync1_reg <= key_raw;
         sync2_reg <= sync1_reg;
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pulse_reg <= pulse_next;
      end
   end

   // The cycle that leaves a stable state already counts as the first stable cycle.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pulse_next = 1'b0;
      case (state_reg)
         RELEASED: begin
            if (!sync2_reg) begin
               state_next = PRESS_WAIT;
               cnt_next   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (sync2_reg) begin
               state_next = RELEASED;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = PRESSED;
               cnt_next   = '0;
               pulse_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         PRESSED: begin
            if (sync2_reg) begin
               state_next = RELEASE_WAIT;
               cnt_next   = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (!sync2_reg) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = RELEASED;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            state_next = RELEASED;
            cnt_next   = '0;
         end
      endcase
   end

   assign level = !((state_reg == PRESSED) || (state_reg == RELEASE_WAIT));
   assign pulse = pulse_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Front-panel conditioner: debounced Run/Continue keys and the switch bank.
// Define SWITCH_SYNC_EN to pass S_raw through a 2-flop synchronizer.
module btn_conditioner
   import slc3_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Run_raw,
   input  logic        Continue_raw,
   input  logic [15:0] S_raw,
   output logic        Run,
   output logic        Continue,
   output logic        Run_pulse,
   output logic        Continue_pulse,
   output logic [15:0] S
);

   logic [1:0] key_raw;
   logic [1:0] key_level;
   logic [1:0] key_pulse;

   assign key_raw = {Continue_raw, Run_raw};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_key
         btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk    (Clk),
            .rst    (Reset),
            .key_raw(key_raw[gi]),
            .level  (key_level[gi]),
            .pulse  (key_pulse[gi])
         );
      end
   endgenerate

   assign Run            = key_level[0];
   assign Continue       = key_level[1];
   assign Run_pulse      = key_pulse[0];
   assign Continue_pulse = key_pulse[1];

`ifdef SWITCH_SYNC_EN
   logic [15:0] s_sync1_reg;
   logic [15:0] s_sync2_reg;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s_sync1_reg <= '0;
         s_sync2_reg <= '0;
      end else begin
         s_sync1_reg <= S_raw;
         s_sync2_reg <= s_sync1_reg;
      end
   end

   assign S = s_sync2_reg;
`else
   assign S = S_raw;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES = 4.
module tb_btn_conditioner;

   localparam int N = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Run_raw;
   logic        Continue_raw;
   logic [15:0] S_raw;
   logic        Run;
   logic        Continue;
   logic        Run_pulse;
   logic        Continue_pulse;
   logic [15:0] S;

   always #5 Clk = ~Clk;

   btn_conditioner #(
      .DEBOUNCE_CYCLES(N)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Run_raw       (Run_raw),
      .Continue_raw  (Continue_raw),
      .S_raw         (S_raw),
      .Run           (Run),
      .Continue      (Continue),
      .Run_pulse     (Run_pulse),
      .Continue_pulse(Continue_pulse),
      .S             (S)
   );

   int checks = 0;
   int passes = 0;
   int rp_cnt = 0;
   int cp_cnt = 0;

   task automatic check_bit(input string name, input logic got, input logic want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s at %0t: got %b, want %b", name, $time, got, want);
   endtask

   task automatic check_word(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got === want) passes++;
      else $display("FAIL %s at %0t: got %h, want %h", name, $time, got, want);
   endtask

   // Reference: the key value seen by the debouncer is the raw pin two edges
   // late; the accepted level flips once N consecutive seen samples disagree.
   logic        m_d1 [2];
   logic        m_d2 [2];
   logic        m_acc[2];
   logic        m_pls[2];
   int          m_run[2];
   logic [15:0] m_s1;
   logic [15:0] m_s2;

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_d1[k] = 1'b1; m_d2[k] = 1'b1; m_acc[k] = 1'b1; m_pls[k] = 1'b0; m_run[k] = 0;
      end
      m_s1 = '0;
      m_s2 = '0;
   endfunction

   function automatic void model_step(input logic r, input logic c, input logic [15:0] sw);
      logic raw [2];
      logic seen;
      raw[0] = r;
      raw[1] = c;
      for (int k = 0; k < 2; k++) begin
         seen     = m_d2[k];
         m_d2[k]  = m_d1[k];
         m_d1[k]  = raw[k];
         m_pls[k] = 1'b0;
         if (seen != m_acc[k]) begin
            m_run[k]++;
            if (m_run[k] == N) begin
               m_acc[k] = seen;
               m_run[k] = 0;
               m_pls[k] = (seen == 1'b0);
            end
         end else begin
            m_run[k] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = sw;
   endfunction

   function automatic logic [15:0] model_s(input logic [15:0] sw);
`ifdef SWITCH_SYNC_EN
      return m_s2;
`else
      return sw;
`endif
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic tick(input logic r, input logic c, input logic [15:0] sw);
      Run_raw      = r;
      Continue_raw = c;
      S_raw        = sw;
      @(posedge Clk);
      model_step(r, c, sw);
      #1;
      check_bit("run_level", Run, m_acc[0]);
      check_bit("cont_level", Continue, m_acc[1]);
      check_bit("run_pulse", Run_pulse, m_pls[0]);
      check_bit("cont_pulse", Continue_pulse, m_pls[1]);
      check_word("s_out", S, model_s(sw));
      if (Run_pulse) rp_cnt++;
      if (Continue_pulse) cp_cnt++;
      @(negedge Clk);
   endtask

   task automatic reset_checks(input logic [15:0] sw);
      check_bit("rst_run", Run, 1'b1);
      check_bit("rst_cont", Continue, 1'b1);
      check_bit("rst_run_pulse", Run_pulse, 1'b0);
      check_bit("rst_cont_pulse", Continue_pulse, 1'b0);
`ifdef SWITCH_SYNC_EN
      check_word("rst_s", S, 16'h0000);
`else
      check_word("rst_s", S, sw);
`endif
   endtask

   // Asserts Reset between edges so the first check shows the asynchronous clear.
   task automatic do_reset(input int cycles, input logic r, input logic c, input logic [15:0] sw);
      Reset        = 1'b1;
      Run_raw      = r;
      Continue_raw = c;
      S_raw        = sw;
      model_reset();
      #1;
      reset_checks(sw);
      repeat (cycles) begin
         @(posedge Clk);
         #1;
         reset_checks(sw);
         @(negedge Clk);
      end
      Reset  = 1'b0;
      rp_cnt = 0;
      cp_cnt = 0;
   endtask

   typedef struct {
      logic        run_raw;
      logic        cont_raw;
      logic [15:0] s_raw;
      logic        exp_run;
      logic        exp_cont;
      logic        exp_rp;
      logic        exp_cp;
      logic [15:0] exp_s;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int first_pulse;
      logic rv;
      logic cv;
      int run_left;
      int cont_left;

      // Simultaneous press for 8 cycles, then simultaneous release for 8.
      for (int i = 0; i < 16; i++) begin
         tbl[i].run_raw  = (i >= 8);
         tbl[i].cont_raw = (i >= 8);
         tbl[i].s_raw    = (i < 8) ? 16'hA5C3 : 16'h3C5A;
         tbl[i].exp_run  = (i < 5) || (i >= 13);
         tbl[i].exp_cont = (i < 5) || (i >= 13);
         tbl[i].exp_rp   = (i == 5);
         tbl[i].exp_cp   = (i == 5);
`ifdef SWITCH_SYNC_EN
         tbl[i].exp_s    = (i == 0) ? 16'h0000 : tbl[i-1].s_raw;
`else
         tbl[i].exp_s    = tbl[i].s_raw;
`endif
      end

      // Key already held low during reset: one pulse six cycles after release.
      do_reset(3, 1'b0, 1'b1, 16'h1234);
      for (int t = 0; t < 8; t++) begin
         tick(1'b0, 1'b1, 16'h1234);
         check_bit("held_run", Run, (t >= 5) ? 1'b0 : 1'b1);
         check_bit("held_pulse", Run_pulse, (t == 5) ? 1'b1 : 1'b0);
      end
      repeat (100) tick(1'b0, 1'b1, 16'h1234);
      check_word("held_pulse_count", 16'(rp_cnt), 16'd1);
      repeat (8) tick(1'b1, 1'b1, 16'h1234);
      check_bit("release_level", Run, 1'b1);
      check_word("release_no_pulse", 16'(rp_cnt), 16'd1);

      do_reset(2, 1'b1, 1'b1, 16'h0000);
      for (int i = 0; i < 16; i++) begin
         tick(tbl[i].run_raw, tbl[i].cont_raw, tbl[i].s_raw);
         check_bit("tbl_run", Run, tbl[i].exp_run);
         check_bit("tbl_cont", Continue, tbl[i].exp_cont);
         check_bit("tbl_run_pulse", Run_pulse, tbl[i].exp_rp);
         check_bit("tbl_cont_pulse", Continue_pulse, tbl[i].exp_cp);
         check_word("tbl_s", S, tbl[i].exp_s);
      end

      // Bounce 0,1,0,1 then stable low: single pulse 5 ticks after the last edge.
      rp_cnt = 0;
      first_pulse = -1;
      for (int t = 0; t < 12; t++) begin
         tick((t < 4) ? 1'(t % 2) : 1'b0, 1'b1, 16'h0F0F);
         if (Run_pulse && first_pulse < 0) first_pulse = t;
      end
      check_word("bounce_pulse_count", 16'(rp_cnt), 16'd1);
      check_word("bounce_pulse_tick", 16'(first_pulse), 16'd9);
      repeat (10) tick(1'b1, 1'b1, 16'h0F0F);

      // Low for N-1 cycles is rejected; low for exactly N cycles is accepted.
      rp_cnt = 0;
      repeat (3) tick(1'b0, 1'b1, 16'h0F0F);
      repeat (10) tick(1'b1, 1'b1, 16'h0F0F);
      check_word("glitch3_pulses", 16'(rp_cnt), 16'd0);
      repeat (4) tick(1'b0, 1'b1, 16'h0F0F);
      repeat (10) tick(1'b1, 1'b1, 16'h0F0F);
      check_word("press4_pulses", 16'(rp_cnt), 16'd1);

      // Reset mid-debounce, then a full restart is required.
      repeat (3) tick(1'b0, 1'b1, 16'hBEEF);
      do_reset(2, 1'b0, 1'b1, 16'hBEEF);
      for (int t = 0; t < 8; t++) begin
         tick(1'b0, 1'b1, 16'hBEEF);
         check_bit("mid_rst_pulse", Run_pulse, (t == 5) ? 1'b1 : 1'b0);
      end
      check_bit("pressed_before_rst", Run, 1'b0);
      do_reset(1, 1'b1, 1'b1, 16'hA5C3);

      // Random bouncy keys and switches against the reference model.
      run_left  = 0;
      cont_left = 0;
      rv = 1'b1;
      cv = 1'b1;
      for (int t = 0; t < 3000; t++) begin
         if (run_left == 0) begin
            rv = 1'($urandom_range(0, 1));
            run_left = int'($urandom_range(1, 8));
         end
         if (cont_left == 0) begin
            cv = 1'($urandom_range(0, 1));
            cont_left = int'($urandom_range(1, 8));
         end
         run_left--;
         cont_left--;
         tick(rv, cv, 16'($urandom));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
